// File: rtl/demux_1_4_reg_if.sv
// Handshake bundle for demux_1_4_reg: one producer port (d/sel/vld/rdy) and
// four consumer channels (yN/y_vld/y_rdy). The master side drives the inputs.
interface demux_1_4_reg_if #(
   parameter int W = 4
);
   logic [W-1:0] d;
   logic [1:0]   sel;
   logic         vld;
   logic         rdy;
   logic [W-1:0] y0;
   logic [W-1:0] y1;
   logic [W-1:0] y2;
   logic [W-1:0] y3;
   logic [3:0]   y_vld;
   logic [3:0]   y_rdy;

   modport master (
      output d, sel, vld, y_rdy,
      input  rdy, y0, y1, y2, y3, y_vld
   );

   modport slave (
      input  d, sel, vld, y_rdy,
      output rdy, y0, y1, y2, y3, y_vld
   );
endinterface

// File: rtl/demux_1_4_reg.sv
// Registered 1-to-4 demultiplexer, one holding register per channel so a stalled
// channel never blocks the others. Define DEMUX_1_4_REG_COUNT_EN for per-channel transfer counters.
module demux_1_4_reg #(
   parameter int W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   demux_1_4_reg_if.slave        bus
`ifdef DEMUX_1_4_REG_COUNT_EN
   ,
   output logic [31:0]           cnt
`endif
);

   logic [W-1:0] y_q [4];
   logic [W-1:0] y_d [4];
   logic [3:0]   vld_q;
   logic [3:0]   vld_d;
   logic [3:0]   drain;
   logic         accept;

   // Ready looks only at the selected channel, so other channels stay independent.
   assign bus.rdy = !vld_q[bus.sel] || bus.y_rdy[bus.sel];
   assign accept  = bus.vld && bus.rdy;

   always_comb begin
      drain = 4'b0000;
      vld_d = vld_q;
      for (int n = 0; n < 4; n++) begin
         y_d[n] = y_q[n];
      end
      for (int n = 0; n < 4; n++) begin
         drain[n] = vld_q[n] && bus.y_rdy[n];
         if (accept && (bus.sel == n[1:0])) begin
            y_d[n]   = bus.d;
            vld_d[n] = 1'b1;
         end else if (drain[n]) begin
            vld_d[n] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= 4'b0000;
         for (int n = 0; n < 4; n++) begin
            y_q[n] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int n = 0; n < 4; n++) begin
            y_q[n] <= y_d[n];
         end
      end
   end

   assign bus.y0    = y_q[0];
   assign bus.y1    = y_q[1];
   assign bus.y2    = y_q[2];
   assign bus.y3    = y_q[3];
   assign bus.y_vld = vld_q;

`ifdef DEMUX_1_4_REG_COUNT_EN
   logic [7:0] cnt_q [4];
   logic [7:0] cnt_d [4];

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         cnt_d[n] = drain[n] ? cnt_q[n] + 8'd1 : cnt_q[n];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int n = 0; n < 4; n++) begin
            cnt_q[n] <= 8'd0;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            cnt_q[n] <= cnt_d[n];
         end
      end
   end

   assign cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux_1_4_reg.sv
// Directed self-checking bench for demux_1_4_reg; inputs change and outputs are
// sampled 1 ns after the rising edge.
module tb_demux_1_4_reg;
   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   demux_1_4_reg_if #(.W(W)) bus ();

`ifdef DEMUX_1_4_REG_COUNT_EN
   logic [31:0] cnt;
   demux_1_4_reg #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .cnt(cnt));
`else
   demux_1_4_reg #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] data);
      bus.vld = v;
      bus.sel = s;
      bus.d   = data;
      #1;
   endtask

   task automatic check_y(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input logic [W-1:0] e2, input logic [W-1:0] e3);
      check({tag, "_y0"}, 32'(bus.y0), 32'(e0));
      check({tag, "_y1"}, 32'(bus.y1), 32'(e1));
      check({tag, "_y2"}, 32'(bus.y2), 32'(e2));
      check({tag, "_y3"}, 32'(bus.y3), 32'(e3));
   endtask

   initial begin
      logic [W-1:0] route_d [4];
      checks   = 0;
      failures = 0;
      route_d  = '{4'h3, 4'h9, 4'hC, 4'h6};
      rst_n     = 1'b0;
      bus.y_rdy = 4'b0000;
      drive(1'b0, 2'd0, 4'h0);
      cyc();
      cyc();
      check("rst_yvld", 32'(bus.y_vld), 32'h0);
      check_y("rst", 4'h0, 4'h0, 4'h0, 4'h0);
      check("rst_rdy", 32'(bus.rdy), 32'h1);
      rst_n = 1'b1;

      // Basic routing
      bus.y_rdy = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'(i), route_d[i]);
         check("route_rdy", 32'(bus.rdy), 32'h1);
         cyc();
         check("route_yvld", 32'(bus.y_vld), 32'(4'b0001 << i));
      end
      check_y("route", 4'h3, 4'h9, 4'hC, 4'h6);
      drive(1'b0, 2'd0, 4'h0);
      cyc();
      check("route_drain", 32'(bus.y_vld), 32'h0);

      // Channel stall isolation
      bus.y_rdy = 4'b1110;
      drive(1'b1, 2'd0, 4'h5);
      check("stall_rdy5", 32'(bus.rdy), 32'h1);
      cyc();
      check("stall_yvld5", 32'(bus.y_vld), 32'b0001);
      drive(1'b1, 2'd0, 4'h6);
      check("stall_rdy6", 32'(bus.rdy), 32'h0);
      cyc();
      check("stall_hold_yvld", 32'(bus.y_vld), 32'b0001);
      check("stall_hold_y0", 32'(bus.y0), 32'h5);
      drive(1'b1, 2'd1, 4'h7);
      check("stall_rdy7", 32'(bus.rdy), 32'h1);
      cyc();
      check("stall_yvld7", 32'(bus.y_vld), 32'b0011);
      check_y("stall7", 4'h5, 4'h7, 4'hC, 4'h6);
      drive(1'b0, 2'd0, 4'h0);
      cyc();
      check("stall_ch1_drain", 32'(bus.y_vld), 32'b0001);
      bus.y_rdy = 4'b1111;
      drive(1'b1, 2'd0, 4'h6);
      check("stall_release_rdy", 32'(bus.rdy), 32'h1);
      cyc();
      check("stall_release_yvld", 32'(bus.y_vld), 32'b0001);
      check("stall_release_y0", 32'(bus.y0), 32'h6);
      drive(1'b0, 2'd0, 4'h0);
      cyc();
      check("stall_release_drain", 32'(bus.y_vld), 32'h0);

      // Full throughput on channel 2
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 2'd2, 4'(i));
         check("tput_rdy", 32'(bus.rdy), 32'h1);
         cyc();
         check("tput_yvld", 32'(bus.y_vld), 32'b0100);
         check("tput_y2", 32'(bus.y2), 32'(i));
      end
      drive(1'b0, 2'd0, 4'h0);
      cyc();
      check("tput_drain", 32'(bus.y_vld), 32'h0);

      // Idle inputs ignored
      bus.y_rdy = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 2'(i), 4'hF);
         cyc();
         check("idle_yvld", 32'(bus.y_vld), 32'h0);
         check_y("idle", 4'h6, 4'h7, 4'h4, 4'h6);
      end

      // Reset mid-operation, with a competing accept in the reset cycle
      drive(1'b1, 2'd1, 4'h8);
      cyc();
      drive(1'b1, 2'd3, 4'h9);
      cyc();
      check("mid_yvld", 32'(bus.y_vld), 32'b1010);
      check_y("mid", 4'h6, 4'h8, 4'h4, 4'h9);
      rst_n = 1'b0;
      drive(1'b1, 2'd2, 4'hA);
      cyc();
      rst_n = 1'b1;
      drive(1'b0, 2'd1, 4'h0);
      check("mid_rst_yvld", 32'(bus.y_vld), 32'h0);
      check_y("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0);
      check("mid_rst_rdy", 32'(bus.rdy), 32'h1);

`ifdef DEMUX_1_4_REG_COUNT_EN
      check("cnt_after_rst", cnt, 32'h0);
      bus.y_rdy = 4'b1111;
      for (int i = 0; i < 257; i++) begin
         drive(1'b1, 2'd3, 4'(i));
         cyc();
      end
      drive(1'b0, 2'd0, 4'h0);
      cyc();
      check("cnt_ch3", 32'(cnt[31:24]), 32'h1);
      check("cnt_others", 32'(cnt[23:0]), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
